// File: rtl/video_line_doubler.sv
// NES-to-VGA line doubler: a ping-pong line RAM is filled from the PPU and each
// source line is replayed on two VGA lines, with programmable sync timing and scanline dimming.
module video_line_doubler #(
    parameter int   IN_W     = 256,
    parameter int   PIX_W    = 15,
    parameter int   H_ACTIVE = 512,
    parameter int   H_FP     = 58,
    parameter int   H_SYNC   = 80,
    parameter int   H_TOTAL  = 682,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_TOTAL  = 524,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PIX_W-1:0]   in_pixel,
    input  logic               in_valid,
    input  logic               in_line_start,
    input  logic               in_frame_start,
    input  logic [1:0]         scanline_mode,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [PIX_W/3-1:0] vga_r,
    output logic [PIX_W/3-1:0] vga_g,
    output logic [PIX_W/3-1:0] vga_b,
    output logic               vga_blank,
    output logic [10:0]        h_count,
    output logic [10:0]        v_count,
    output logic               line_overrun
);
    localparam int CW = PIX_W / 3;
    localparam int AW = $clog2(IN_W);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0] WR_FULL = (AW + 1)'(IN_W);
    localparam logic [AW:0] WR_ONE  = (AW + 1)'(1);

    function automatic logic [CW-1:0] dim_ch(input logic [CW-1:0] c, input logic [1:0] mode,
                                             input logic odd);
        logic [CW-1:0] res;
        if (!odd) begin
            res = c;
        end else begin
            case (mode)
                2'd1:    res = c - (c >> 2'd2);
                2'd2:    res = c >> 2'd1;
                2'd3:    res = c >> 2'd2;
                default: res = c;
            endcase
        end
        return res;
    endfunction

    logic [10:0]      h_r, v_r, h_next_s, v_next_s;
    logic             wr_bank_r, wr_bank_next_s, rd_bank_r, rd_sel_s;
    logic [AW:0]      wr_addr_r, wr_addr_next_s, mem_waddr_s, rd_addr_s;
    logic             mem_we_s, overrun_s;
    logic [PIX_W-1:0] line_mem [0:2*IN_W-1];
    logic [PIX_W-1:0] rd_data_r;
    logic [10:0]      h1_r, v1_r;
    logic             act1_r, hs1_r, vs1_r, act_s, hs_s, vs_s;

    // Timing counters; a frame start overrides the natural wrap.
    always_comb begin
        h_next_s = h_r + 11'd1;
        v_next_s = v_r;
        if (in_frame_start) begin
            h_next_s = 11'd0;
            v_next_s = 11'd0;
        end else if (h_r == H_LAST) begin
            h_next_s = 11'd0;
            v_next_s = (v_r == V_LAST) ? 11'd0 : v_r + 11'd1;
        end else begin
            v_next_s = v_r;
        end
    end

    // Write-side control: a line start swaps banks and may also carry pixel 0.
    always_comb begin
        mem_we_s       = 1'b0;
        overrun_s      = 1'b0;
        wr_bank_next_s = wr_bank_r;
        wr_addr_next_s = wr_addr_r;
        mem_waddr_s    = {wr_bank_r, wr_addr_r[AW-1:0]};
        if (in_line_start) begin
            wr_bank_next_s = ~wr_bank_r;
            mem_waddr_s    = {~wr_bank_r, {AW{1'b0}}};
            mem_we_s       = in_valid;
            wr_addr_next_s = in_valid ? WR_ONE : {(AW + 1){1'b0}};
        end else if (in_valid) begin
            if (wr_addr_r < WR_FULL) begin
                mem_we_s       = 1'b1;
                wr_addr_next_s = wr_addr_r + WR_ONE;
            end else begin
                overrun_s = 1'b1;
            end
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Read-side selection; the bank is latched at the start of each even line pair.
    always_comb begin
        rd_sel_s  = rd_bank_r;
        if ((h_r == 11'd0) && !v_r[0]) begin
            rd_sel_s = ~wr_bank_r;
        end else begin
            rd_sel_s = rd_bank_r;
        end
        rd_addr_s = {rd_sel_s, h_r[AW:1]};
        act_s     = (h_r < H_ACT) && (v_r < V_ACT);
        hs_s      = (h_r >= HS_BEG) && (h_r < HS_END);
        vs_s      = (v_r >= VS_BEG) && (v_r < VS_END);
    end

    // Line RAM with registered read (first pipeline stage for colour).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            line_mem[mem_waddr_s] <= in_pixel;
        end
        rd_data_r <= line_mem[rd_addr_s];
    end

    // Counter, write pointer and stage-1 timing registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_r       <= 11'd0;
            v_r       <= 11'd0;
            wr_bank_r <= 1'b0;
            wr_addr_r <= {(AW + 1){1'b0}};
            rd_bank_r <= 1'b1;
            h1_r      <= 11'd0;
            v1_r      <= 11'd0;
            act1_r    <= 1'b0;
            hs1_r     <= 1'b0;
            vs1_r     <= 1'b0;
        end else begin
            h_r       <= h_next_s;
            v_r       <= v_next_s;
            wr_bank_r <= wr_bank_next_s;
            wr_addr_r <= wr_addr_next_s;
            rd_bank_r <= rd_sel_s;
            h1_r      <= h_r;
            v1_r      <= v_r;
            act1_r    <= act_s;
            hs1_r     <= hs_s;
            vs1_r     <= vs_s;
        end
    end

    // Output stage: dimming on odd lines, blanking, sync polarity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_r        <= {CW{1'b0}};
            vga_g        <= {CW{1'b0}};
            vga_b        <= {CW{1'b0}};
            vga_blank    <= 1'b1;
            vga_hs       <= ~HS_POL;
            vga_vs       <= ~VS_POL;
            h_count      <= 11'd0;
            v_count      <= 11'd0;
            line_overrun <= 1'b0;
        end else begin
            if (act1_r) begin
                vga_r <= dim_ch(rd_data_r[CW-1:0], scanline_mode, v1_r[0]);
                vga_g <= dim_ch(rd_data_r[2*CW-1:CW], scanline_mode, v1_r[0]);
                vga_b <= dim_ch(rd_data_r[3*CW-1:2*CW], scanline_mode, v1_r[0]);
            end else begin
                vga_r <= {CW{1'b0}};
                vga_g <= {CW{1'b0}};
                vga_b <= {CW{1'b0}};
            end
            vga_blank    <= ~act1_r;
            vga_hs       <= hs1_r ? HS_POL : ~HS_POL;
            vga_vs       <= vs1_r ? VS_POL : ~VS_POL;
            h_count      <= h1_r;
            v_count      <= v1_r;
            line_overrun <= overrun_s;
        end
    end
endmodule

// File: tb/tb_video_line_doubler.sv
// Scoreboard bench for video_line_doubler: default-timing instance plus a
// positive-sync, short-frame instance for polarity and frame-length checks.
module tb_video_line_doubler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] in_pixel;
    logic        in_valid, in_line_start, in_frame_start;
    logic [1:0]  scanline_mode;
    logic        vga_hs, vga_vs, vga_blank, line_overrun;
    logic [4:0]  vga_r, vga_g, vga_b;
    logic [10:0] h_count, v_count;
    logic        p_hs, p_vs, p_blank, p_ovr;
    logic [4:0]  p_r, p_g, p_b;
    logic [10:0] p_hc, p_vc;
    logic [14:0] pix_s;
    logic [14:0] exp_even[$];
    logic [14:0] exp_odd[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    assign pix_s = {vga_b, vga_g, vga_r};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_line_doubler dut (
        .clk(clk), .reset_n(reset_n), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_line_start(in_line_start), .in_frame_start(in_frame_start),
        .scanline_mode(scanline_mode), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_blank(vga_blank),
        .h_count(h_count), .v_count(v_count), .line_overrun(line_overrun)
    );

    video_line_doubler #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_TOTAL(14),
                         .HS_POL(1'b1), .VS_POL(1'b1)) dut_p (
        .clk(clk), .reset_n(reset_n), .in_pixel(15'd0), .in_valid(1'b0),
        .in_line_start(1'b0), .in_frame_start(1'b0), .scanline_mode(2'd0),
        .vga_hs(p_hs), .vga_vs(p_vs), .vga_r(p_r), .vga_g(p_g), .vga_b(p_b),
        .vga_blank(p_blank), .h_count(p_hc), .v_count(p_vc), .line_overrun(p_ovr)
    );

    task automatic wait_pos(input int hc, input int vpar, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!(h_count == 11'(hc) && (vpar < 0 || v_count[0] == vpar[0])) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (h_count == 11'(hc) && (vpar < 0 || v_count[0] == vpar[0]));
    endtask

    task automatic test_reset();
        in_pixel = 15'd0; in_valid = 1'b0; in_line_start = 1'b0;
        in_frame_start = 1'b0; scanline_mode = 2'd0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (vga_blank !== 1'b1) begin errors++; $display("FAIL rst_blank: got %b want 1", vga_blank); end
        checks++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin errors++; $display("FAIL rst_sync: got hs %b vs %b want 1 1", vga_hs, vga_vs); end
        checks++; if (pix_s !== 15'd0) begin errors++; $display("FAIL rst_rgb: got %h want 0", pix_s); end
        checks++; if (h_count !== 11'd0 || v_count !== 11'd0) begin errors++; $display("FAIL rst_count: got %0d/%0d want 0/0", h_count, v_count); end
        checks++; if (line_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", line_overrun); end
        checks++; if (p_hs !== 1'b0 || p_vs !== 1'b0 || p_blank !== 1'b1) begin errors++; $display("FAIL rst_pol: got hs %b vs %b blank %b want 0 0 1", p_hs, p_vs, p_blank); end
        reset_n = 1'b1;
    endtask

    task automatic test_hs_timing();
        int n, t0;
        n = 0;
        while (vga_hs !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        checks++; if (vga_hs !== 1'b0 || h_count !== 11'd570 || v_count !== 11'd0) begin errors++; $display("FAIL hs_first: got hs %b at h %0d v %0d want 0 at 570/0", vga_hs, h_count, v_count); end
        t0 = cyc; n = 0;
        while (vga_hs !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        checks++; if (cyc - t0 !== 80) begin errors++; $display("FAIL hs_width: got %0d want 80", cyc - t0); end
        n = 0;
        while (vga_hs !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        checks++; if (cyc - t0 !== 682 || v_count !== 11'd1) begin errors++; $display("FAIL hs_period: got %0d v %0d want 682 v 1", cyc - t0, v_count); end
    endtask

    task automatic test_ramp();
        bit ok;
        int lv;
        logic [14:0] e;
        wait_pos(10, -1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ramp_sync: got %0d want 1", ok); end
        for (int i = 0; i < 256; i++) begin
            in_pixel = 15'(i); in_valid = 1'b1; in_line_start = (i == 0);
            exp_even.push_back(15'(i)); exp_even.push_back(15'(i));
            exp_odd.push_back(15'(i));  exp_odd.push_back(15'(i));
            @(negedge clk);
        end
        in_valid = 1'b0; in_line_start = 1'b1;
        @(negedge clk);
        in_line_start = 1'b0;
        wait_pos(0, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ramp_even_start: got %0d want 1", ok); end
        lv = int'(v_count);
        for (int k = 0; k < 512; k++) begin
            e = exp_even.pop_front();
            checks++; if (pix_s !== e || vga_blank !== 1'b0) begin errors++; $display("FAIL ramp_even h=%0d: got %0d blank %b want %0d blank 0", h_count, pix_s, vga_blank, e); end
            @(negedge clk);
        end
        checks++; if (vga_blank !== 1'b1 || pix_s !== 15'd0) begin errors++; $display("FAIL ramp_tail: got blank %b rgb %0d want 1 0", vga_blank, pix_s); end
        wait_pos(0, 1, ok);
        checks++; if (!ok || v_count !== 11'(lv + 1)) begin errors++; $display("FAIL ramp_odd_start: got v %0d want %0d", v_count, lv + 1); end
        for (int k = 0; k < 512; k++) begin
            e = exp_odd.pop_front();
            checks++; if (pix_s !== e || vga_blank !== 1'b0) begin errors++; $display("FAIL ramp_odd h=%0d: got %0d blank %b want %0d blank 0", h_count, pix_s, vga_blank, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_scanline();
        bit ok;
        logic [14:0] e;
        logic [14:0] base;
        logic [14:0] odd_tab [4];
        int order [4];
        base = {5'd9, 5'd20, 5'd31};
        odd_tab = '{{5'd9, 5'd20, 5'd31}, {5'd7, 5'd15, 5'd24}, {5'd4, 5'd10, 5'd15}, {5'd2, 5'd5, 5'd7}};
        order = '{2, 3, 1, 0};
        wait_pos(10, -1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL scan_sync: got %0d want 1", ok); end
        for (int i = 0; i < 256; i++) begin
            in_pixel = base; in_valid = 1'b1; in_line_start = (i == 0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_line_start = 1'b1;
        @(negedge clk);
        in_line_start = 1'b0;
        for (int m = 0; m < 4; m++) begin
            scanline_mode = 2'(order[m]);
            for (int k = 0; k < 16; k++) begin
                exp_even.push_back(base);
                exp_odd.push_back(odd_tab[order[m]]);
            end
            wait_pos(0, 0, ok);
            for (int k = 0; k < 16; k++) begin
                e = exp_even.pop_front();
                checks++; if (!ok || pix_s !== e) begin errors++; $display("FAIL scan_even mode=%0d h=%0d: got %h want %h", order[m], h_count, pix_s, e); end
                @(negedge clk);
            end
            wait_pos(0, 1, ok);
            for (int k = 0; k < 16; k++) begin
                e = exp_odd.pop_front();
                checks++; if (!ok || pix_s !== e) begin errors++; $display("FAIL scan_odd mode=%0d h=%0d: got %h want %h", order[m], h_count, pix_s, e); end
                @(negedge clk);
            end
        end
        scanline_mode = 2'd0;
    endtask

    task automatic test_overrun();
        bit ok;
        int cnt;
        logic [14:0] e;
        cnt = 0;
        wait_pos(10, -1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_sync: got %0d want 1", ok); end
        for (int k = 0; k < 257; k++) begin
            in_pixel = 15'(100 + k); in_valid = 1'b1; in_line_start = (k == 0);
            if (k == 0) exp_even.push_back(15'd100);
            if (k == 255) begin exp_even.push_back(15'd355); exp_even.push_back(15'd355); end
            @(negedge clk);
            if (line_overrun === 1'b1) cnt++;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (line_overrun === 1'b1) cnt++;
        end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", cnt); end
        in_line_start = 1'b1;
        @(negedge clk);
        in_line_start = 1'b0;
        wait_pos(0, 0, ok);
        e = exp_even.pop_front();
        checks++; if (!ok || pix_s !== e) begin errors++; $display("FAIL ovr_pix0: got %0d want %0d", pix_s, e); end
        wait_pos(510, 0, ok);
        e = exp_even.pop_front();
        checks++; if (!ok || pix_s !== e) begin errors++; $display("FAIL ovr_pix510: got %0d want %0d", pix_s, e); end
        @(negedge clk);
        e = exp_even.pop_front();
        checks++; if (pix_s !== e) begin errors++; $display("FAIL ovr_pix511: got %0d want %0d", pix_s, e); end
    endtask

    task automatic test_frame_start();
        bit ok;
        int n;
        wait_pos(298, -1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fs_sync: got %0d want 1", ok); end
        in_frame_start = 1'b1;
        @(negedge clk);
        in_frame_start = 1'b0;
        checks++; if (h_count !== 11'd299) begin errors++; $display("FAIL fs_lag1: got %0d want 299", h_count); end
        @(negedge clk);
        checks++; if (h_count !== 11'd300) begin errors++; $display("FAIL fs_lag2: got %0d want 300", h_count); end
        @(negedge clk);
        checks++; if (h_count !== 11'd0 || v_count !== 11'd0) begin errors++; $display("FAIL fs_zero: got %0d/%0d want 0/0", h_count, v_count); end
        n = 0;
        while (vga_hs !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        checks++; if (vga_hs !== 1'b0 || h_count !== 11'd570 || v_count !== 11'd0) begin errors++; $display("FAIL fs_hs: got hs %b at %0d/%0d want 0 at 570/0", vga_hs, h_count, v_count); end
    endtask

    task automatic test_polarity();
        int n, t0;
        n = 0;
        while (p_hs !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        t0 = cyc; n = 0;
        while (p_hs !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        checks++; if (cyc - t0 !== 80) begin errors++; $display("FAIL pol_hs_width: got %0d want 80", cyc - t0); end
        n = 0;
        while (p_vs !== 1'b1 && n < 12000) begin @(negedge clk); n++; end
        t0 = cyc; n = 0;
        while (p_vs !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        checks++; if (cyc - t0 !== 1364) begin errors++; $display("FAIL pol_vs_width: got %0d want 1364", cyc - t0); end
        n = 0;
        while (p_vs !== 1'b1 && n < 12000) begin @(negedge clk); n++; end
        checks++; if (cyc - t0 !== 9548) begin errors++; $display("FAIL pol_frame: got %0d want 9548", cyc - t0); end
    endtask

    task automatic test_reset_midline();
        bit ok;
        wait_pos(100, -1, ok);
        checks++; if (!ok || vga_blank !== 1'b0) begin errors++; $display("FAIL mid_pre: got blank %b want 0", vga_blank); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (vga_blank !== 1'b1 || pix_s !== 15'd0 || h_count !== 11'd0 || vga_hs !== 1'b1) begin errors++; $display("FAIL mid_async: got blank %b rgb %0d h %0d hs %b want 1 0 0 1", vga_blank, pix_s, h_count, vga_hs); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (h_count !== 11'd1 || v_count !== 11'd0) begin errors++; $display("FAIL mid_restart: got %0d/%0d want 1/0", h_count, v_count); end
    endtask

    initial begin
        test_reset();
        test_hs_timing();
        test_ramp();
        test_scanline();
        test_overrun();
        test_frame_start();
        test_polarity();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
